// File: rtl/lsr_line_gen.sv
// Line generator: streams y[i] = b + m*i for i = 0..DATA_SIZE-1 over valid/ready, one add per sample.
// Optional clamping of out_data to the signed WIDTH range is enabled by defining LSR_SAT_EN.
module lsr_line_gen #(
  parameter int unsigned DATA_SIZE = 16,
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ACC_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic signed [WIDTH-1:0] m_i,
  input  logic signed [WIDTH-1:0] b_i,
  input  logic                    out_ready_i,
  output logic                    out_valid_o,
  output logic signed [WIDTH-1:0] out_data_o,
  output logic [15:0]             out_idx_o,
  output logic                    out_last_o,
  output logic                    out_sat_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam logic [15:0] LastIdx = 16'(DATA_SIZE - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [15:0]             idx_q, idx_d;
  logic signed [WIDTH-1:0] m_q, m_d;
  logic                    done_q, done_d;
  logic                    is_last;
  logic                    run;

  assign is_last = (idx_q == LastIdx);
  assign run     = (state_q == StRun);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      idx_q   <= '0;
      m_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      m_q     <= m_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    m_d     = m_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRun;
          m_d     = m_i;
          acc_d   = {{(ACC_W-WIDTH){b_i[WIDTH-1]}}, b_i};
          idx_d   = '0;
        end
      end
      StRun: begin
        if (out_ready_i) begin
          if (is_last) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            acc_d = acc_q + {{(ACC_W-WIDTH){m_q[WIDTH-1]}}, m_q};
            idx_d = idx_q + 16'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef LSR_SAT_EN
  // acc fits in WIDTH bits iff its top ACC_W-WIDTH+1 bits are all equal.
  logic [ACC_W-WIDTH:0] acc_top;
  logic                 in_range;
  assign acc_top  = acc_q[ACC_W-1:WIDTH-1];
  assign in_range = (&acc_top) | ~(|acc_top);
`endif

  always_comb begin
    out_valid_o = run;
    busy_o      = run;
    done_o      = done_q;
    out_idx_o   = '0;
    out_last_o  = 1'b0;
    out_data_o  = '0;
    out_sat_o   = 1'b0;
    if (run) begin
      out_idx_o  = idx_q;
      out_last_o = is_last;
`ifdef LSR_SAT_EN
      if (in_range) begin
        out_data_o = acc_q[WIDTH-1:0];
      end else begin
        out_sat_o  = 1'b1;
        out_data_o = acc_q[ACC_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
`else
      out_data_o = acc_q[WIDTH-1:0];
`endif
    end
  end

endmodule

// File: tb/tb_lsr_line_gen.sv
// Directed bench for lsr_line_gen with DATA_SIZE=4; expected values are hand-computed.
module tb_lsr_line_gen;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start_i;
  logic signed [15:0] m_i, b_i;
  logic               out_ready_i;
  logic               out_valid_o;
  logic signed [15:0] out_data_o;
  logic [15:0]        out_idx_o;
  logic               out_last_o, out_sat_o, busy_o, done_o;

  int n_vec = 0;
  int n_bad = 0;

  lsr_line_gen #(
    .DATA_SIZE(4),
    .WIDTH    (16),
    .ACC_W    (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .m_i        (m_i),
    .b_i        (b_i),
    .out_ready_i(out_ready_i),
    .out_valid_o(out_valid_o),
    .out_data_o (out_data_o),
    .out_idx_o  (out_idx_o),
    .out_last_o (out_last_o),
    .out_sat_o  (out_sat_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic samp(input int d, input int i, input bit last, input bit sat);
    chk("valid", 16'(out_valid_o), 16'd1);
    chk("busy", 16'(busy_o), 16'd1);
    chk("data", out_data_o, 16'(d));
    chk("idx", out_idx_o, 16'(i));
    chk("last", 16'(out_last_o), 16'(last));
    chk("sat", 16'(out_sat_o), 16'(sat));
    chk("done_in_run", 16'(done_o), 16'd0);
  endtask

  task automatic idle_chk(input bit exp_done);
    chk("idle_valid", 16'(out_valid_o), 16'd0);
    chk("idle_busy", 16'(busy_o), 16'd0);
    chk("idle_idx", out_idx_o, 16'd0);
    chk("idle_done", 16'(done_o), 16'(exp_done));
  endtask

  task automatic kick(input int m, input int b);
    start_i = 1'b1;
    m_i     = 16'(m);
    b_i     = 16'(b);
    step();
    start_i = 1'b0;
  endtask

  // Four full-rate samples b + m*i, then the done cycle (left current).
  task automatic run4(input int b, input int m);
    for (int i = 0; i < 4; i++) begin
      samp(b + m * i, i, i == 3, 1'b0);
      step();
    end
    idle_chk(1'b1);
  endtask

  initial begin
    rst_n       = 1'b0;
    start_i     = 1'b0;
    m_i         = '0;
    b_i         = '0;
    out_ready_i = 1'b1;
    step();
    step();
    idle_chk(1'b0);
    chk("rst_data", out_data_o, 16'd0);
    chk("rst_last", 16'(out_last_o), 16'd0);
    chk("rst_sat", 16'(out_sat_o), 16'd0);
    rst_n = 1'b1;
    step();
    idle_chk(1'b0);

    // Basic run
    kick(3, -5);
    run4(-5, 3);
    step();
    idle_chk(1'b0);

    // Backpressure at idx=1
    kick(3, -5);
    samp(-5, 0, 1'b0, 1'b0);
    step();
    out_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      samp(-2, 1, 1'b0, 1'b0);
      step();
    end
    out_ready_i = 1'b1;
    samp(-2, 1, 1'b0, 1'b0);
    step();
    samp(1, 2, 1'b0, 1'b0);
    step();
    samp(4, 3, 1'b1, 1'b0);
    step();
    idle_chk(1'b1);
    step();
    idle_chk(1'b0);

    // Start (and m/b changes) ignored during a run
    kick(3, -5);
    samp(-5, 0, 1'b0, 1'b0);
    step();
    samp(-2, 1, 1'b0, 1'b0);
    step();
    start_i = 1'b1;
    m_i     = 16'sd7;
    b_i     = 16'sd7;
    samp(1, 2, 1'b0, 1'b0);
    step();
    start_i = 1'b0;
    samp(4, 3, 1'b1, 1'b0);
    step();
    idle_chk(1'b1);
    step();
    kick(7, 7);
    run4(7, 7);

    // Back-to-back: start accepted in the done cycle
    kick(-1, 2);
    run4(2, -1);
    step();
    idle_chk(1'b0);

    // Overflow
    kick(20000, 20000);
`ifdef LSR_SAT_EN
    samp(20000, 0, 1'b0, 1'b0);
    step();
    samp(32767, 1, 1'b0, 1'b1);
    step();
    samp(32767, 2, 1'b0, 1'b1);
    step();
    samp(32767, 3, 1'b1, 1'b1);
    step();
`else
    samp(20000, 0, 1'b0, 1'b0);
    step();
    samp(-25536, 1, 1'b0, 1'b0);
    step();
    samp(-5536, 2, 1'b0, 1'b0);
    step();
    samp(14464, 3, 1'b1, 1'b0);
    step();
`endif
    idle_chk(1'b1);
    step();

    // Asynchronous reset mid-run at idx=2
    kick(3, -5);
    samp(-5, 0, 1'b0, 1'b0);
    step();
    samp(-2, 1, 1'b0, 1'b0);
    step();
    samp(1, 2, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    idle_chk(1'b0);
    step();
    idle_chk(1'b0);
    rst_n = 1'b1;
    step();
    idle_chk(1'b0);
    kick(0, 100);
    run4(100, 0);
    step();
    idle_chk(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
